// File: rtl/sabr_prod_rescale.sv
// Rescales the raw SABR multiplier product to path format: round-half-up, shift, saturate.
// Optional saturation event counter on ovf_cnt when PROD_OVF_CNT_EN is defined.
module sabr_prod_rescale #(
   parameter int IN_W    = 93,
   parameter int FRAC_SH = 44,
   parameter int OUT_W   = 49,
   parameter int CNT_W   = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic [IN_W-1:0]  in_prod,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef PROD_OVF_CNT_EN
   output logic [CNT_W-1:0] ovf_cnt,
`endif
   output logic             out_sat
);

   localparam int RW = IN_W + 1 - FRAC_SH;
   localparam int EW = ((RW > OUT_W) ? RW : OUT_W) + 1;

   // Sum kept one bit wider than the product so the rounding carry is never lost.
   function automatic logic [RW-1:0] round_shift(input logic [IN_W-1:0] p);
      logic [IN_W:0] s;
      s = {1'b0, p} + ({{IN_W{1'b0}}, 1'b1} << (FRAC_SH - 1));
      return s[IN_W:FRAC_SH];
   endfunction

   function automatic logic is_sat(input logic [RW-1:0] r);
      logic [EW-1:0] re;
      logic [EW-1:0] lim;
      re  = EW'(r);
      lim = {{(EW-1){1'b0}}, 1'b1} << OUT_W;
      return re >= lim;
   endfunction

   function automatic logic [OUT_W-1:0] sat_val(input logic [RW-1:0] r);
      logic [EW-1:0] re;
      re = EW'(r);
      return is_sat(r) ? {OUT_W{1'b1}} : re[OUT_W-1:0];
   endfunction

   logic [RW-1:0] r_p1;
   logic          vld_p1;
   logic          s1_adv;
   logic          s2_adv;

   assign s2_adv   = vld_p1 && (!out_valid || out_ready);
   assign in_ready = !vld_p1 || s2_adv;
   assign s1_adv   = in_valid && in_ready;

   // Stage 1: round and shift
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         vld_p1 <= 1'b0;
      end else if (s1_adv) begin
         vld_p1 <= 1'b1;
      end else if (s2_adv) begin
         vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (s1_adv) begin
         r_p1 <= round_shift(in_prod);
      end
   end

   // Stage 2: saturate into the output register
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= 1'b1;
         out_data  <= sat_val(r_p1);
         out_sat   <= is_sat(r_p1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef PROD_OVF_CNT_EN
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         ovf_cnt <= '0;
      end else if (out_valid && out_ready && out_sat && (ovf_cnt != {CNT_W{1'b1}})) begin
         ovf_cnt <= ovf_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sabr_prod_rescale.sv
// Directed bench for sabr_prod_rescale: rounding, saturation, backpressure, reset flush.
// Counter checks are compiled in when PROD_OVF_CNT_EN is defined.
module tb_sabr_prod_rescale;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic [92:0] in_prod;
   logic        in_valid;
   logic        in_ready;
   logic [48:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sat;
`ifdef PROD_OVF_CNT_EN
   logic [15:0] ovf_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   localparam logic [92:0] ONE = 93'd1;
   localparam logic [48:0] MAX49 = {49{1'b1}};

   sabr_prod_rescale dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .in_prod   (in_prod),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef PROD_OVF_CNT_EN
      .ovf_cnt   (ovf_cnt),
`endif
      .out_sat   (out_sat)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic run_one(input string tag, input logic [92:0] p,
                          input logic [48:0] ed, input logic es);
      in_prod   = p;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, "_inrdy"}, 128'(in_ready), 128'd1);
      tick();
      in_valid = 1'b0;
      chk({tag, "_lat1"}, 128'(out_valid), 128'd0);
      tick();
      chk({tag, "_vld"}, 128'(out_valid), 128'd1);
      chk({tag, "_data"}, 128'(out_data), 128'(ed));
      chk({tag, "_sat"}, 128'(out_sat), 128'(es));
      tick();
      chk({tag, "_drain"}, 128'(out_valid), 128'd0);
   endtask

   initial begin
      logic [92:0] vals [8];
      logic [48:0] exps [8];
      logic        rdy_pat [4];
      int acc, emit, cyc;
      logic hs_in, hs_out;

      ap_rst = 1'b1; in_prod = '0; in_valid = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_vld", 128'(out_valid), 128'd0);
      chk("rst_data", 128'(out_data), 128'd0);
      chk("rst_sat", 128'(out_sat), 128'd0);
      chk("rst_inrdy", 128'(in_ready), 128'd1);
`ifdef PROD_OVF_CNT_EN
      chk("rst_cnt", 128'(ovf_cnt), 128'd0);
`endif
      ap_rst = 1'b0;
      tick();

      run_one("one",      ONE << 44,                    49'd1, 1'b0);
      run_one("tie",      ONE << 43,                    49'd1, 1'b0);
      run_one("below",    (ONE << 43) - 1,              49'd0, 1'b0);
      run_one("zero",     93'd0,                        49'd0, 1'b0);
      run_one("3p5",      (ONE << 45) + (ONE << 44) + (ONE << 43), 49'd4, 1'b0);
      run_one("maxexact", 93'(MAX49) << 44,             MAX49, 1'b0);
      run_one("allones",  {93{1'b1}},                   MAX49, 1'b1);
`ifdef PROD_OVF_CNT_EN
      chk("cnt_first", 128'(ovf_cnt), 128'd1);
`endif
      run_one("carrysat", (93'(MAX49) << 44) + (ONE << 43), MAX49, 1'b1);
`ifdef PROD_OVF_CNT_EN
      chk("cnt_second", 128'(ovf_cnt), 128'd2);
`endif

      // Streaming under backpressure with ready pattern 1,0,0,1
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         vals[i] = (93'(i + 10) << 44) + ((i % 2 == 1) ? (ONE << 43) : 93'd0);
         exps[i] = 49'(i + 10 + (i % 2));
      end
      acc = 0; emit = 0; cyc = 0;
      while (emit < 8 && cyc < 60) begin
         in_valid  = (acc < 8);
         in_prod   = (acc < 8) ? vals[acc] : 93'd0;
         out_ready = rdy_pat[cyc % 4];
         #1;
         chk("str_inrdy", 128'(in_ready), 128'((acc - emit) < 2 || out_ready));
         hs_in  = in_valid && in_ready;
         hs_out = out_valid && out_ready;
         if (hs_out) begin
            chk("str_data", 128'(out_data), 128'(exps[emit]));
            emit++;
         end
         if (hs_in) acc++;
         tick();
         cyc++;
      end
      chk("str_count", 128'(emit), 128'd8);
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("str_nodup", 128'(out_valid), 128'd0);

      // Reset with two results buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_prod   = {93{1'b1}};
      tick();
      in_prod   = ONE << 44;
      tick();
      in_valid  = 1'b0;
      #1;
      chk("full_inrdy", 128'(in_ready), 128'd0);
      ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0;
      chk("rst2_vld", 128'(out_valid), 128'd0);
      chk("rst2_inrdy", 128'(in_ready), 128'd1);
`ifdef PROD_OVF_CNT_EN
      chk("rst2_cnt", 128'(ovf_cnt), 128'd0);
`endif
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst2_stale", 128'(out_valid), 128'd0);
      end

`ifdef PROD_OVF_CNT_EN
      in_prod  = {93{1'b1}};
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 70000; k++) tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("cnt_hold", 128'(ovf_cnt), 128'd65535);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
